pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller that sequences the five pipeline-register stages: PC, IF/ID, ID/EX, EX/MEM, and the MEM/WB store stage.
- Generates per-stage enables, flushes and a writeback bubble.
- Handles load-use hazards, taken-branch flushes, and variable-latency data-memory accesses (req/ready handshake with timeout).
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
RWIDTH, 5, register-address width
MEM_TIMEOUT, 64, max WAIT cycles before an access is abandoned (must be >=2)
CWIDTH, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
mem_rd  input  1  load in MEM stage
mem_wr  input  1  store in MEM stage
dmem_ready  input  1  data memory completes current access this cycle
ex_is_load  input  1  instruction in EX is a load
ex_rd  input  RWIDTH  destination register of EX instruction
id_rs1  input  RWIDTH  source 1 of ID instruction
id_rs2  input  RWIDTH  source 2 of ID instruction
branch_taken  input  1  taken branch resolved in EX
perf_clr  input  1  synchronous clear of stall_count and mem_err
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID enable
id_ex_en  output  1  ID/EX enable
ex_mem_en  output  1  EX/MEM enable
mem_wb_en  output  1  MEM/WB store-stage enable
if_id_flush  output  1  load NOP into IF/ID
id_ex_flush  output  1  load NOP into ID/EX
mem_wb_bubble  output  1  store stage captures NOP instead of MEM result
dmem_req  output  1  data-memory request
dmem_we  output  1  write qualifier, equals mem_wr while dmem_req is high
mem_err  output  1  sticky: an access timed out
stall_count  output  CWIDTH  stall cycles, saturating

Behaviour:
- FSM states: IDLE, WAIT. Registered: state, wait counter wcnt, mem_err, stall_count. All other outputs are combinational from state and inputs.
- Reset: state=IDLE, wcnt=0, mem_err=0, stall_count=0.
  - With all inputs 0: all *_en=1, flushes=0, mem_wb_bubble=0, dmem_req=0.
  - Reset in WAIT aborts the access immediately; no error is flagged.
- Definitions: mem_op = mem_rd|mem_wr. dmem_req = (IDLE & mem_op) | WAIT.
- Zero-wait access: IDLE & mem_op & dmem_ready completes in the same cycle with no stall.
- Memory stall: mstall = dmem_req & !dmem_ready & !tout, where tout = WAIT & (wcnt==MEM_TIMEOUT-1).
- Transitions:
  - IDLE: mem_op & !dmem_ready -> WAIT, wcnt=0.
  - WAIT: dmem_ready -> IDLE.
  - WAIT: tout -> IDLE; set mem_err; assert mem_wb_bubble that cycle.
  - Otherwise in WAIT: wcnt++.
  - If dmem_ready and tout coincide, ready wins: no error, no bubble.
- Load-use: luse = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority (highest first):
  - mstall: all five *_en=0; no flushes.
    - branch_taken and luse remain pending and are applied on the release cycle, because the stages hold their contents.
  - branch_taken: all en=1, if_id_flush=1, id_ex_flush=1. Overrides luse, since the dependent instruction is flushed.
  - luse: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
    - Exactly one bubble per load-use; the next cycle EX holds the NOP, so luse is 0.
  - none: all en=1, no flushes.
- stall_count increments each cycle where mstall|luse (luse counted only if not overridden).
  - Saturates at all-ones.
  - perf_clr has priority: count=0 and mem_err=0 that cycle.
- dmem_we=mem_wr&dmem_req. mem_rd&mem_wr both high is treated as a store.
- mem_op must stay stable while in WAIT, which is guaranteed since EX/MEM is frozen.

Test Plan:
- After reset, idle inputs -> all en=1, dmem_req=0, stall_count=0, mem_err=0.
- mem_rd=1 with dmem_ready high on the 4th cycle of the request -> dmem_req high 4 cycles, all en=0 for 3 cycles, en=1 on the ready cycle, stall_count=3.
- ex_is_load=1, ex_rd=5, id_rs2=5 -> one cycle with pc_en=if_id_en=0 and id_ex_flush=1, stall_count=1. The same case with ex_rd=0 produces no stall.
- Load-use plus branch_taken in the same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, stall_count unchanged. Branch asserted during a memory stall -> flushes only on the release cycle.
- MEM_TIMEOUT=4, mem_wr=1, dmem_ready=0 -> dmem_we=1, mem_err=1 and mem_wb_bubble=1 on the 5th request cycle, stall_count=4. perf_clr then clears both.
- rst asserted mid-WAIT -> state IDLE, mem_err=0. Saturation: preload via 2^CWIDTH stall cycles with CWIDTH=4 -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequences the five pipeline-register stages (PC, IF/ID, ID/EX, EX/MEM,
//   MEM/WB store stage). Resolves load-use hazards, taken-branch flushes and
//   variable-latency data-memory accesses (req/ready handshake with timeout).
//   Keeps a saturating stall-cycle counter for performance monitoring.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mem_rd, mem_wr      load / store sitting in the MEM stage
//   dmem_ready          data memory completes the current access this cycle
//   ex_is_load, ex_rd   EX instruction is a load, and its destination
//   id_rs1, id_rs2      ID instruction sources
//   branch_taken        taken branch resolved in EX
//   perf_clr            synchronous clear of stall_count and mem_err
//   *_en                per-stage register enables
//   if_id_flush,
//   id_ex_flush         load a NOP into IF/ID, ID/EX
//   mem_wb_bubble       store stage captures a NOP (abandoned access)
//   dmem_req, dmem_we   data-memory request and write qualifier
//   mem_err             sticky access-timeout flag
//   stall_count         saturating stall-cycle counter
module pipe_hazard_ctrl #(
    parameter int RWIDTH      = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CWIDTH      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              dmem_ready,
    input  logic              ex_is_load,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic [RWIDTH-1:0] id_rs1,
    input  logic [RWIDTH-1:0] id_rs2,
    input  logic              branch_taken,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_bubble,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              mem_err,
    output logic [CWIDTH-1:0] stall_count
);

    localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          mem_op, tout, mstall, luse, stall_inc;

    // Hazard detection and next-state logic.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;

        mem_op   = mem_rd | mem_wr;
        tout     = (state == WAIT) && (wcnt == WLAST);
        dmem_req = ((state == IDLE) && mem_op) || (state == WAIT);
        dmem_we  = mem_wr & dmem_req;
        mstall   = dmem_req & ~dmem_ready & ~tout;
        luse     = ex_is_load && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));

        // An expiring access ends with a bubble unless ready arrives the
        // same cycle, in which case the data is real.
        mem_wb_bubble = tout & ~dmem_ready;

        case (state)
            IDLE: begin
                if (mem_op && !dmem_ready) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = '0;
                end
            end
            WAIT: begin
                if (dmem_ready || tout) state_nxt = IDLE;
                else                    wcnt_nxt  = wcnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage control. During a memory stall every stage holds, so a pending
    // branch or load-use is simply re-evaluated on the release cycle.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;

        if (mstall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            stall_inc = 1'b1;
        end else if (branch_taken) begin
            // The dependent instruction of any load-use is flushed here.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (luse) begin
            // Hold PC and IF/ID, inject one NOP into ID/EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else if (perf_clr) begin
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (mem_wb_bubble) mem_err <= 1'b1;
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int RW   = 5;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_rd = 0, mem_wr = 0, dmem_ready = 0, ex_is_load = 0;
    logic [RW-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic branch_taken = 0, perf_clr = 0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req, dmem_we, mem_err;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: whether an access is outstanding, how many
    // cycles it has been outstanding (including its first IDLE cycle),
    // the sticky error and the stall counter as a plain integer.
    bit m_wait = 0;
    int m_age  = 0;
    bit m_err  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RWIDTH(RW), .MEM_TIMEOUT(TO), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dmem_ready(dmem_ready), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .branch_taken(branch_taken),
        .perf_clr(perf_clr), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .mem_err(mem_err), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (we sit at a negedge).
    // Check everything against the model, then advance model and DUT.
    task automatic cyc();
        bit op, req, tout, bub, ms, lu, inc;
        logic [4:0] en;
        logic [1:0] fl;
        #1;
        if (rst) begin
            m_wait = 0; m_age = 0; m_err = 0; m_cnt = 0;
        end
        op   = mem_rd | mem_wr;
        req  = m_wait ? 1'b1 : op;
        tout = m_wait && (m_age == TO);
        bub  = tout && !dmem_ready;
        ms   = req && !dmem_ready && !tout;
        lu   = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (ms)                en = 5'b00000;
        else if (branch_taken) en = 5'b11111;
        else if (lu)           en = 5'b00111;
        else                   en = 5'b11111;
        fl  = (!ms && branch_taken) ? 2'b11 : (!ms && lu) ? 2'b01 : 2'b00;
        inc = ms || (lu && !branch_taken);

        chk("en",     {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, en);
        chk("flush",  {if_id_flush, id_ex_flush}, fl);
        chk("bubble", mem_wb_bubble, bub);
        chk("req",    dmem_req, req);
        chk("we",     dmem_we, req & mem_wr);
        chk("err",    mem_err, m_err);
        chk("count",  stall_count, m_cnt);

        if (!rst) begin
            if (!m_wait) begin
                if (op && !dmem_ready) begin m_wait = 1; m_age = 1; end
            end else if (dmem_ready || tout) m_wait = 0;
            else m_age++;
            if (perf_clr) begin
                m_cnt = 0; m_err = 0;
            end else begin
                if (inc && m_cnt < CMAX) m_cnt++;
                if (bub) m_err = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        mem_rd = 0; mem_wr = 0; dmem_ready = 0; ex_is_load = 0;
        ex_rd = '0; id_rs1 = '0; id_rs2 = '0; branch_taken = 0; perf_clr = 0;
    endtask

    initial begin
        bit hold_rd, hold_wr;
        @(negedge clk);
        // Reset state with idle inputs.
        cyc(); cyc();
        rst = 0;
        cyc();

        // Read completing on the 4th request cycle.
        mem_rd = 1;
        repeat (3) cyc();
        dmem_ready = 1; cyc();
        idle_in(); cyc();
        chk("rd4_count", stall_count, 3);

        // Load-use: exactly one bubble, then the NOP in EX clears it.
        perf_clr = 1; cyc(); perf_clr = 0;
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; cyc();
        ex_is_load = 0; cyc();
        chk("luse_count", stall_count, 1);
        ex_is_load = 1; ex_rd = 0; id_rs2 = 0; id_rs1 = 0; cyc();
        chk("luse_r0", stall_count, 1);

        // Load-use overridden by a taken branch.
        ex_rd = 7; id_rs1 = 7; branch_taken = 1; cyc();
        chk("br_luse_count", stall_count, 1);
        idle_in();

        // Branch pending during a memory stall, applied on release.
        mem_rd = 1; branch_taken = 1;
        repeat (2) cyc();
        dmem_ready = 1; cyc();
        idle_in(); cyc();

        // Store timeout: error and bubble on the 5th request cycle.
        perf_clr = 1; cyc(); perf_clr = 0;
        mem_wr = 1;
        repeat (5) cyc();
        idle_in(); cyc();
        chk("tout_count", stall_count, 4);
        chk("tout_err", mem_err, 1);
        perf_clr = 1; cyc(); perf_clr = 0;
        chk("clr_count", stall_count, 0);
        chk("clr_err", mem_err, 0);

        // Ready coinciding with the timeout cycle: no error.
        mem_rd = 1;
        repeat (4) cyc();
        dmem_ready = 1; cyc();
        idle_in(); cyc();
        chk("tie_err", mem_err, 0);

        // Error set, then reset in the middle of a WAIT.
        mem_wr = 1; repeat (5) cyc();
        idle_in(); mem_rd = 1; repeat (2) cyc();
        rst = 1; mem_rd = 0; cyc();
        rst = 0; cyc();
        chk("rst_err", mem_err, 0);

        // Saturation: 5 back-to-back timeouts give 20 stall cycles.
        mem_rd = 1; repeat (25) cyc();
        idle_in(); cyc();
        chk("sat", stall_count, CMAX);
        ex_is_load = 1; ex_rd = 3; id_rs1 = 3; cyc();
        chk("sat_hold", stall_count, CMAX);
        idle_in(); perf_clr = 1; cyc(); perf_clr = 0;

        // Random traffic; mem_rd/mem_wr are held while an access waits.
        hold_rd = 0; hold_wr = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_wait) begin
                hold_rd = ($urandom_range(0, 3) == 0);
                hold_wr = ($urandom_range(0, 4) == 0);
            end
            mem_rd       = hold_rd;
            mem_wr       = hold_wr;
            dmem_ready   = ($urandom_range(0, 3) == 0);
            ex_is_load   = $urandom_range(0, 1);
            ex_rd        = RW'($urandom_range(0, 3));
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 5) == 0);
            perf_clr     = ($urandom_range(0, 40) == 0);
            rst          = ($urandom_range(0, 150) == 0);
            if (rst) begin hold_rd = 0; hold_wr = 0; end
            cyc();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
